// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with dead time,
// leading-zero blanking and frame-synchronous (tear-free) updates.
module seg7_scan_driver #(
   parameter int NDIGITS      = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1,
   localparam int CW = $clog2(REFRESH_DIV)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [4*NDIGITS-1:0] value,
   input  logic [NDIGITS-1:0]   dp,
   input  logic [NDIGITS-1:0]   digit_en,
   input  logic                 lz_blank,
   output logic [7:0]           seg,
   output logic [NDIGITS-1:0]   an,
   output logic [IW-1:0]        digit_idx,
   output logic                 frame_tick
);

   typedef enum logic {BLANK, DRIVE} state_t;

   localparam state_t RST_STATE = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   state_t state;
   logic [CW-1:0] slot_cnt;
   logic [CW-1:0] slot_nxt;
   logic [IW-1:0] idx_nxt;
   logic          slot_end;

   logic [4*NDIGITS-1:0] sh_val;
   logic [4*NDIGITS-1:0] ac_val;
   logic [NDIGITS-1:0]   sh_dp;
   logic [NDIGITS-1:0]   sh_en;
   logic [NDIGITS-1:0]   ac_dp;
   logic [NDIGITS-1:0]   ac_en;

   logic [3:0]         nib;
   logic               cur_dp;
   logic               cur_en;
   logic               lzb;
   logic [NDIGITS-1:0] an_d;
   logic [7:0]         seg_d;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h01;
         4'h1: glyph = 7'h4F;
         4'h2: glyph = 7'h12;
         4'h3: glyph = 7'h06;
         4'h4: glyph = 7'h4C;
         4'h5: glyph = 7'h24;
         4'h6: glyph = 7'h20;
         4'h7: glyph = 7'h0F;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h0C;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h60;
         4'hC: glyph = 7'h31;
         4'hD: glyph = 7'h42;
         4'hE: glyph = 7'h30;
         4'hF: glyph = 7'h38;
      endcase
   endfunction

   always_comb begin
      slot_end   = (slot_cnt == CW'(REFRESH_DIV - 1));
      frame_tick = slot_end && (digit_idx == IW'(NDIGITS - 1));
      slot_nxt   = slot_end ? '0 : slot_cnt + 1'b1;
      idx_nxt    = digit_idx;
      if (slot_end)
         idx_nxt = (digit_idx == IW'(NDIGITS - 1)) ? '0 : digit_idx + 1'b1;

      nib    = ac_val[4*digit_idx +: 4];
      cur_dp = ac_dp[digit_idx];
      cur_en = ac_en[digit_idx];
      // blanked when this and every more-significant nibble is zero
      lzb    = lz_blank && (digit_idx != '0)
               && ((ac_val >> (4*digit_idx)) == '0);

      an_d  = '1;
      seg_d = 8'hFF;
      if (state == DRIVE && cur_en) begin
         if (!lzb) begin
            an_d  = ~(NDIGITS'(1) << digit_idx);
            seg_d = {~cur_dp, glyph(nib)};
         end else if (cur_dp) begin
            an_d  = ~(NDIGITS'(1) << digit_idx);
            seg_d = 8'h7F;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RST_STATE;
         slot_cnt  <= '0;
         digit_idx <= '0;
         an        <= '1;
         seg       <= 8'hFF;
         sh_val    <= '0;
         sh_dp     <= '0;
         sh_en     <= '0;
         ac_val    <= '0;
         ac_dp     <= '0;
         ac_en     <= '0;
      end else begin
         slot_cnt  <= slot_nxt;
         digit_idx <= idx_nxt;
         state     <= (int'(slot_nxt) < BLANK_CYCLES) ? BLANK : DRIVE;
         an        <= an_d;
         seg       <= seg_d;
         if (load) begin
            sh_val <= value;
            sh_dp  <= dp;
            sh_en  <= digit_en;
         end
         // a load landing on the boundary goes straight to the display
         if (frame_tick) begin
            ac_val <= load ? value    : sh_val;
            ac_dp  <= load ? dp       : sh_dp;
            ac_en  <= load ? digit_en : sh_en;
         end
      end
   end

endmodule
